// File: rtl/alu_bist_pkg.sv
// rtl/alu_bist_pkg.sv - shared types and constants for the ALU BIST sequencer
//
// Contents:
//   bist_state_t            sequencer FSM states
//   CNT_W                   width of the run / failure counters
//   DEFAULT_TIMEOUT_CYCLES  default per-run watchdog limit
//   sat_inc()               saturating increment for CNT_W-bit counters
package alu_bist_pkg;

    localparam int CNT_W                  = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        START,
        WAIT,
        NEXT,
        REPORT
    } bist_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/alu_bist_watchdog.sv
// rtl/alu_bist_watchdog.sv - loadable up-counter with terminal-count flag
//
// Parameters:
//   TO_W            counter width, 2^TO_W > TIMEOUT_CYCLES
//   TIMEOUT_CYCLES  terminal count is TIMEOUT_CYCLES-1
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   load     clear the counter to 0 (has priority over enable)
//   enable   count up by one
//   tc       high while the counter equals TIMEOUT_CYCLES-1
module alu_bist_watchdog #(
    parameter int TO_W           = 11,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam logic [TO_W-1:0] TC_VALUE = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !tc) begin
            // Holding at terminal count keeps the flag asserted and avoids wrap.
            count <= count + TO_W'(1);
        end
    end

    assign tc = (count == TC_VALUE);

endmodule

// File: rtl/alu_bist_sequencer.sv
// rtl/alu_bist_sequencer.sv - initiator for the ALU BIST start/done/pass/fail handshake
//
// Runs the ALU self-test NUM_RUNS times per launch with a per-run watchdog
// and reports aggregate status.
//
// Parameters:
//   NUM_RUNS        runs per launch, 1..255
//   TIMEOUT_CYCLES  cycles from bist_start to bist_done before timeout, >= 2
//   TO_W            watchdog width, 2^TO_W > TIMEOUT_CYCLES
// Build option:
//   ALU_BIST_STOP_ON_FAIL_EN  end the sequence after the first bad run
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   launch        one-cycle start request, accepted only when idle
//   busy          sequence in progress
//   bist_start    one-cycle start pulse to alu_bist_top
//   bist_done     done level from alu_bist_top
//   bist_pass     pass flag, valid with bist_done
//   bist_fail     fail flag, valid with bist_done
//   result_valid  one-cycle pulse when the sequence ends
//   result_pass   all runs good; held until next launch
//   fail_count    failed / timed-out / protocol-error runs
//   runs_done     runs completed
//   timeout_err   sticky: some run timed out
//   proto_err     sticky: some done arrived with pass==fail
module alu_bist_sequencer
    import alu_bist_pkg::*;
#(
    parameter int NUM_RUNS       = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TO_W           = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             launch,
    output logic             busy,
    output logic             bist_start,
    input  logic             bist_done,
    input  logic             bist_pass,
    input  logic             bist_fail,
    output logic             result_valid,
    output logic             result_pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] runs_done,
    output logic             timeout_err,
    output logic             proto_err
);

    localparam logic [CNT_W-1:0] NUM_RUNS_C = CNT_W'(NUM_RUNS);

    bist_state_t state;
    bist_state_t state_next;

    logic wd_tc;
    logic run_end;
    logic run_bad;
    logic run_proto;
    logic seq_end;

    alu_bist_watchdog #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state == START),
        .enable  (state == WAIT),
        .tc      (wd_tc)
    );

    // A run ends on done or on watchdog expiry; done wins when both coincide,
    // so a done on the last allowed cycle is judged on its pass/fail flags.
    assign run_end   = bist_done || wd_tc;
    assign run_proto = bist_done && (bist_pass == bist_fail);
    assign run_bad   = !bist_done || !(bist_pass && !bist_fail);

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    assign seq_end = (runs_done == NUM_RUNS_C) || (fail_count != '0);
`else
    assign seq_end = (runs_done == NUM_RUNS_C);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        bist_start   = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // A done level left over from the previous run must fall first.
                if (!bist_done) begin
                    state_next = START;
                end
            end
            START: begin
                busy       = 1'b1;
                bist_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (run_end) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                busy       = 1'b1;
                state_next = seq_end ? REPORT : DRAIN;
            end
            REPORT: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_pass <= 1'b0;
            fail_count  <= '0;
            runs_done   <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        result_pass <= 1'b0;
                        fail_count  <= '0;
                        runs_done   <= '0;
                        timeout_err <= 1'b0;
                        proto_err   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (run_end) begin
                        runs_done <= sat_inc(runs_done);
                        if (run_bad) begin
                            fail_count <= sat_inc(fail_count);
                        end
                        if (run_proto) begin
                            proto_err <= 1'b1;
                        end
                        if (!bist_done) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    // Registered here so it is already valid alongside result_valid.
                    if (seq_end) begin
                        result_pass <= (fail_count == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// tb/tb_alu_bist_sequencer.sv - directed self-checking bench for alu_bist_sequencer
module tb_alu_bist_sequencer;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [1:0] launch;
    logic [1:0] bist_done;
    logic [1:0] bist_pass;
    logic [1:0] bist_fail;
    logic [1:0] busy;
    logic [1:0] bist_start;
    logic [1:0] result_valid;
    logic [1:0] result_pass;
    logic [1:0] timeout_err;
    logic [1:0] proto_err;
    logic [7:0] fc0, fc1, rd0, rd1;

    // Responder model state, index 0 = dut, 1 = dut_t.
    logic [1:0] force_done;
    logic [1:0] done_m;
    logic [1:0] pass_m;
    logic [1:0] fail_m;
    int         lat[2];
    int         bad_run[2];
    int         bad_kind[2];
    int         cnt[2];
    int         run_idx[2];
    int         starts[2];
    int         rvs[2];

    int checks   = 0;
    int failures = 0;
    int cyc;
    bit ok;

    assign bist_done = force_done | done_m;
    assign bist_pass = pass_m;
    assign bist_fail = fail_m;

    alu_bist_sequencer #(
        .NUM_RUNS       (4),
        .TIMEOUT_CYCLES (1024),
        .TO_W           (11)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .launch       (launch[0]),
        .busy         (busy[0]),
        .bist_start   (bist_start[0]),
        .bist_done    (bist_done[0]),
        .bist_pass    (bist_pass[0]),
        .bist_fail    (bist_fail[0]),
        .result_valid (result_valid[0]),
        .result_pass  (result_pass[0]),
        .fail_count   (fc0),
        .runs_done    (rd0),
        .timeout_err  (timeout_err[0]),
        .proto_err    (proto_err[0])
    );

    alu_bist_sequencer #(
        .NUM_RUNS       (4),
        .TIMEOUT_CYCLES (16),
        .TO_W           (5)
    ) dut_t (
        .clk          (clk),
        .reset_n      (reset_n),
        .launch       (launch[1]),
        .busy         (busy[1]),
        .bist_start   (bist_start[1]),
        .bist_done    (bist_done[1]),
        .bist_pass    (bist_pass[1]),
        .bist_fail    (bist_fail[1]),
        .result_valid (result_valid[1]),
        .result_pass  (result_pass[1]),
        .fail_count   (fc1),
        .runs_done    (rd1),
        .timeout_err  (timeout_err[1]),
        .proto_err    (proto_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // alu_bist_top stand-in: done for one cycle, lat cycles after start.
    // lat=0 never answers; bad_kind 1 = fail, 2 = pass and fail both high.
    initial begin
        done_m = '0;
        pass_m = '0;
        fail_m = '0;
        cnt    = '{-1, -1};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) begin
                    cnt[i]    = -1;
                    done_m[i] = 1'b0;
                    pass_m[i] = 1'b0;
                    fail_m[i] = 1'b0;
                end else if (bist_start[i]) begin
                    starts[i]  = starts[i] + 1;
                    run_idx[i] = run_idx[i] + 1;
                    cnt[i]     = lat[i];
                    done_m[i]  = 1'b0;
                end else if (cnt[i] > 0) begin
                    cnt[i] = cnt[i] - 1;
                    if (cnt[i] == 0) begin
                        done_m[i] = 1'b1;
                        pass_m[i] = !(run_idx[i] == bad_run[i] && bad_kind[i] == 1);
                        fail_m[i] = (run_idx[i] == bad_run[i]);
                    end
                end else begin
                    done_m[i] = 1'b0;
                    pass_m[i] = 1'b0;
                    fail_m[i] = 1'b0;
                end
                if (result_valid[i]) begin
                    rvs[i] = rvs[i] + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input int i, input int l, input int br, input int bk);
        lat[i]      = l;
        bad_run[i]  = br;
        bad_kind[i] = bk;
        run_idx[i]  = 0;
        starts[i]   = 0;
        rvs[i]      = 0;
    endtask

    // Returns at the falling edge of the cycle after the launch cycle.
    task automatic pulse_launch(input int i);
        @(negedge clk);
        launch[i] = 1'b1;
        @(negedge clk);
        launch[i] = 1'b0;
    endtask

    // cyc counts cycles since the launch cycle; stops in the REPORT cycle.
    task automatic wait_result(input int i, input int start, output int c, output bit seen);
        c    = start;
        seen = 1'b0;
        while (!seen && c < 5000) begin
            if (result_valid[i]) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                c++;
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        launch     = '0;
        force_done = '0;
        setup(0, 20, 0, 0);
        setup(1, 20, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs_dut", {busy[0], bist_start[0], result_valid[0], result_pass[0],
              timeout_err[0], proto_err[0], fc0, rd0}, 32'h0);
        check("reset_outputs_dut_t", {busy[1], bist_start[1], result_valid[1], result_pass[1],
              timeout_err[1], proto_err[1], fc1, rd1}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Healthy, 20-cycle runs.
        setup(0, 20, 0, 0);
        pulse_launch(0);
        check("t1_busy_c1", busy[0], 1);
        check("t1_start_c1", bist_start[0], 0);
        @(negedge clk);
        check("t1_start_c2", bist_start[0], 1);
        wait_result(0, 2, cyc, ok);
        check("t1_result_seen", ok, 1);
        check("t1_latency", cyc, 93);
        check("t1_busy_report", busy[0], 0);
        check("t1_pass", result_pass[0], 1);
        check("t1_fail_count", fc0, 0);
        check("t1_runs_done", rd0, 4);
        check("t1_errs", {timeout_err[0], proto_err[0]}, 0);
        @(negedge clk);
        #1;
        check("t1_rv_pulse", result_valid[0], 0);
        check("t1_pass_held", result_pass[0], 1);
        check("t1_starts", starts[0], 4);
        check("t1_rv_count", rvs[0], 1);

        // Run 2 fails.
        setup(0, 20, 2, 1);
        pulse_launch(0);
        wait_result(0, 1, cyc, ok);
        check("t2_result_seen", ok, 1);
        check("t2_pass", result_pass[0], 0);
        check("t2_fail_count", fc0, 1);
        check("t2_runs_done", rd0, STOP ? 2 : 4);
        check("t2_errs", {timeout_err[0], proto_err[0]}, 0);
        @(negedge clk);
        #1;
        check("t2_starts", starts[0], STOP ? 2 : 4);

        // Run 3 reports pass and fail together.
        setup(0, 20, 3, 2);
        pulse_launch(0);
        wait_result(0, 1, cyc, ok);
        check("t3_result_seen", ok, 1);
        check("t3_proto_err", proto_err[0], 1);
        check("t3_timeout_err", timeout_err[0], 0);
        check("t3_fail_count", fc0, 1);
        check("t3_runs_done", rd0, STOP ? 3 : 4);
        check("t3_pass", result_pass[0], 0);

        // Stale done held at launch blocks the first start.
        setup(0, 20, 0, 0);
        force_done[0] = 1'b1;
        pulse_launch(0);
        repeat (10) @(negedge clk);
        #1;
        check("t4_no_start_while_done", starts[0], 0);
        check("t4_busy_while_drain", busy[0], 1);
        @(negedge clk);
        force_done[0] = 1'b0;
        wait_result(0, 12, cyc, ok);
        check("t4_result_seen", ok, 1);
        check("t4_pass", result_pass[0], 1);
        check("t4_flags_cleared", {proto_err[0], timeout_err[0], fc0}, 0);
        check("t4_runs_done", rd0, 4);

        // Launch while busy and in REPORT is ignored.
        setup(0, 20, 0, 0);
        pulse_launch(0);
        repeat (30) @(negedge clk);
        launch[0] = 1'b1;
        @(negedge clk);
        launch[0] = 1'b0;
        wait_result(0, 32, cyc, ok);
        check("t5_result_seen", ok, 1);
        check("t5_latency", cyc, 93);
        launch[0] = 1'b1;
        @(negedge clk);
        launch[0] = 1'b0;
        check("t5_idle_after_report", busy[0], 0);
        repeat (40) @(negedge clk);
        #1;
        check("t5_starts", starts[0], 4);
        check("t5_rv_count", rvs[0], 1);
        check("t5_still_idle", busy[0], 0);

        // Asynchronous reset during WAIT of run 3.
        setup(0, 20, 0, 0);
        pulse_launch(0);
        repeat (55) @(negedge clk);
        check("t6_runs_before_reset", rd0, 2);
        check("t6_busy_before_reset", busy[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_outputs_in_reset", {busy[0], bist_start[0], result_valid[0], result_pass[0],
              timeout_err[0], proto_err[0], fc0, rd0}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        setup(0, 20, 0, 0);
        pulse_launch(0);
        wait_result(0, 1, cyc, ok);
        check("t6_result_seen", ok, 1);
        check("t6_latency", cyc, 93);
        check("t6_pass", result_pass[0], 1);
        check("t6_counts", {fc0, rd0}, {8'd0, 8'd4});

        // Never done, 16-cycle watchdog.
        setup(1, 0, 0, 0);
        pulse_launch(1);
        wait_result(1, 1, cyc, ok);
        check("t7_result_seen", ok, 1);
        check("t7_latency", cyc, STOP ? 20 : 77);
        check("t7_timeout_err", timeout_err[1], 1);
        check("t7_proto_err", proto_err[1], 0);
        check("t7_fail_count", fc1, STOP ? 1 : 4);
        check("t7_runs_done", rd1, STOP ? 1 : 4);
        check("t7_pass", result_pass[1], 0);

        // Done on the last allowed cycle wins over the timeout.
        setup(1, 16, 0, 0);
        pulse_launch(1);
        wait_result(1, 1, cyc, ok);
        check("t8_result_seen", ok, 1);
        check("t8_latency", cyc, 77);
        check("t8_timeout_err", timeout_err[1], 0);
        check("t8_pass", result_pass[1], 1);
        check("t8_counts", {fc1, rd1}, {8'd0, 8'd4});

        // Done one cycle late: timeout, and the late done is not counted.
        setup(1, 17, 0, 0);
        pulse_launch(1);
        wait_result(1, 1, cyc, ok);
        check("t9_result_seen", ok, 1);
        check("t9_latency", cyc, STOP ? 20 : 77);
        check("t9_timeout_err", timeout_err[1], 1);
        check("t9_proto_err", proto_err[1], 0);
        check("t9_fail_count", fc1, STOP ? 1 : 4);
        check("t9_runs_done", rd1, STOP ? 1 : 4);
        @(negedge clk);
        #1;
        check("t9_starts", starts[1], STOP ? 1 : 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
